sw_sweep_gen: RTL and testbench
===============================

Name: sw_sweep_gen

Overview:
- Synthesisable, parametrised stimulus sequencer with a built-in response checker for the switch/LED lab designs.
- Steps a NIB_W-bit value through its full range, replicated across CHANNELS lanes onto the SW bus, and holds each value for HOLD clocks.
- Samples the design's LED response at the end of each hold window and compares it against the expected loopback.
- Adds selectable sweep direction, start/busy/done handshake, mismatch counting and first-failure capture.

Parameters:
- NIB_W, 4: width of one lane value.
- CHANNELS, 3: number of lane replicas on SW/LED_IN.
- HOLD, 20: clocks each value is held. Must be ≥ 2; elaboration fails otherwise.
- ERR_W, 8: width of the mismatch counter.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  request a sweep; sampled in IDLE only.
- MODE  in  2  0 = down (max→0), 1 = up (0→max), 2 = ping-pong (max→0→max), 3 = treated as down. Sampled on accepted START.
- SW  out  NIB_W*CHANNELS  stimulus = {CHANNELS{X}}; X is the internal value register.
- LED_IN  in  NIB_W*CHANNELS  DUT response, expected equal to SW.
- BUSY  out  1  high while a sweep runs.
- DONE  out  1  one-clock pulse after the final hold window.
- STEP  out  NIB_W+1  index of the current step, from 0.
- ERR_CNT  out  ERR_W  mismatches in the current/last sweep; saturates at all-ones.
- FAIL  out  1  set on first mismatch; cleared on START.
- FIRST_BAD  out  NIB_W  X at the first mismatch.

Behaviour:
- Reset (async, RST_N low): state IDLE; X=0 (so SW=0); BUSY=0; DONE=0; STEP=0; hold_cnt=0; ERR_CNT=0; FAIL=0; FIRST_BAD=0. Asserting reset mid-sweep aborts immediately with no DONE pulse.
- States: IDLE, RUN. DONE is a registered pulse, not a state.
- IDLE:
  - At an edge with START=1: latch MODE and direction.
  - Load X = max (2^NIB_W−1) for down/ping-pong, or 0 for up.
  - Set STEP=0, hold_cnt=0, ERR_CNT=0, FAIL=0, FIRST_BAD=0, BUSY=1; go to RUN.
  - SW shows the first value from the clock after that edge.
- RUN:
  - hold_cnt increments each clock.
  - At the edge where hold_cnt==HOLD−1 (sample edge):
    - Compare LED_IN with SW. On inequality: ERR_CNT+1 (saturating). If FAIL was 0, set FAIL=1 and FIRST_BAD=X.
    - If this is the last step: BUSY←0, DONE←1 for one clock, state←IDLE. X, STEP, ERR_CNT, FAIL and FIRST_BAD keep their values.
    - Otherwise: advance X per direction, STEP+1, hold_cnt←0.
- Step counts (NIB_W=4 in brackets):
  - down / up: 2^NIB_W steps [16].
  - ping-pong: 2^(NIB_W+1)−1 steps [31]. Reverses at X=0; 0 is not repeated; ends at X=max.
- Sweep length: BUSY high for exactly steps×HOLD clocks.
- START while BUSY: ignored; no restart.
- START high in the same clock DONE pulses: state is already IDLE, so the next edge accepts it (back-to-back sweeps allowed).
- MODE changes during RUN: no effect.
- LED_IN is treated as synchronous to CLK; the block adds no synchroniser. Only the sample edge compares; glitches earlier in the window are ignored.
- Width rules:
  - X wraps only through explicit direction control, never by overflow.
  - STEP is NIB_W+1 bits, wide enough for the ping-pong count.
  - ERR_CNT saturates rather than wrapping.

Test Plan (NIB_W=4, CHANNELS=3, HOLD=4 unless stated):
- Down sweep, LED_IN tied to SW, START pulsed 1 clock, MODE=0:
  - SW = FFF, EEE, … 000, each for 4 clocks.
  - BUSY high 64 clocks, DONE pulses once on the clock after the final window.
  - ERR_CNT=0, FAIL=0.
- Up sweep, MODE=1, loopback: SW = 000 → FFF; STEP reaches 15; DONE after 64 clocks; final SW=FFF held in IDLE.
- Ping-pong, MODE=2, loopback:
  - 31 steps, 124 BUSY clocks.
  - Sequence F…0…F; 000 appears for exactly one window.
  - DONE once.
- Fault injection, down sweep:
  - LED_IN = SW, except bit 0 of lane 0 forced to 1 during X=4 and X=2.
  - Result: ERR_CNT=2, FAIL=1, FIRST_BAD=4.
  - A glitch forced only at hold_cnt=1 produces no error.
- Handshake corners:
  - START re-asserted mid-run: ignored; sweep length unchanged.
  - START held high across DONE: a second sweep begins next clock with ERR_CNT cleared.
  - MODE=3 behaves as down.
- Async reset mid-sweep (RST_N low at step 7 for 3 clocks, not aligned to CLK):
  - All outputs return to reset values immediately; no DONE.
  - After release, IDLE until START.

Source files
------------

// File: rtl/sw_sweep_gen_if.sv
// rtl/sw_sweep_gen_if.sv - stimulus/response bundle between sweep generator and lab design
interface sw_sweep_gen_if #(
  parameter int NIB_W    = 4,
  parameter int CHANNELS = 3,
  parameter int ERR_W    = 8
);
  logic                      START;
  logic [1:0]                MODE;
  logic [NIB_W*CHANNELS-1:0] SW;
  logic [NIB_W*CHANNELS-1:0] LED_IN;
  logic                      BUSY;
  logic                      DONE;
  logic [NIB_W:0]            STEP;
  logic [ERR_W-1:0]          ERR_CNT;
  logic                      FAIL;
  logic [NIB_W-1:0]          FIRST_BAD;

  modport master (
    input  START, MODE, LED_IN,
    output SW, BUSY, DONE, STEP, ERR_CNT, FAIL, FIRST_BAD
  );

  modport slave (
    output START, MODE, LED_IN,
    input  SW, BUSY, DONE, STEP, ERR_CNT, FAIL, FIRST_BAD
  );
endinterface

// File: rtl/sw_sweep_gen.sv
// rtl/sw_sweep_gen.sv - value sweep sequencer driving SW with LED loopback checking
module sw_sweep_gen #(
  parameter int NIB_W    = 4,
  parameter int CHANNELS = 3,
  parameter int HOLD     = 20,
  parameter int ERR_W    = 8
) (
  input  logic           CLK,
  input  logic           RST_N,
  sw_sweep_gen_if.master bus
);

  if (HOLD < 2) begin : g_bad_hold
    $error("sw_sweep_gen: HOLD must be at least 2");
  end

  localparam int                 HOLD_W    = (HOLD < 2) ? 1 : $clog2(HOLD);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD - 1);
  localparam logic [NIB_W-1:0]   X_MAX     = '1;
  localparam logic [NIB_W:0]     LAST_LIN  = (NIB_W+1)'((1 << NIB_W) - 1);
  localparam logic [NIB_W:0]     LAST_PP   = (NIB_W+1)'((1 << (NIB_W + 1)) - 2);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t              state_q, state_d;
  logic [NIB_W-1:0]    x_q, x_d;
  logic                up_q, up_d;
  logic                pp_q, pp_d;
  logic [NIB_W:0]      step_q, step_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                done_q, done_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic                fail_q, fail_d;
  logic [NIB_W-1:0]    first_bad_q, first_bad_d;

  logic [NIB_W*CHANNELS-1:0] sw_w;
  logic                      mismatch;
  logic [NIB_W:0]            last_step;

  assign sw_w      = {CHANNELS{x_q}};
  assign mismatch  = (bus.LED_IN != sw_w);
  assign last_step = pp_q ? LAST_PP : LAST_LIN;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    up_d        = up_q;
    pp_d        = pp_q;
    step_d      = step_q;
    hold_d      = hold_q;
    done_d      = 1'b0;
    err_d       = err_q;
    fail_d      = fail_q;
    first_bad_d = first_bad_q;

    case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          up_d        = (bus.MODE == 2'd1);
          pp_d        = (bus.MODE == 2'd2);
          x_d         = (bus.MODE == 2'd1) ? '0 : X_MAX;
          step_d      = '0;
          hold_d      = '0;
          err_d       = '0;
          fail_d      = 1'b0;
          first_bad_d = '0;
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        hold_d = hold_q + 1'b1;
        if (hold_q == HOLD_LAST) begin
          if (mismatch) begin
            if (err_q != '1) err_d = err_q + 1'b1;
            if (!fail_q) begin
              fail_d      = 1'b1;
              first_bad_d = x_q;
            end
          end
          if (step_q == last_step) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            hold_d  = '0;
          end else begin
            step_d = step_q + 1'b1;
            hold_d = '0;
            // Only ping-pong ever advances from 0 while heading down: turn around there.
            if (up_q) begin
              x_d = x_q + 1'b1;
            end else if (x_q == '0) begin
              x_d  = {{(NIB_W-1){1'b0}}, 1'b1};
              up_d = 1'b1;
            end else begin
              x_d = x_q - 1'b1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      up_q        <= 1'b0;
      pp_q        <= 1'b0;
      step_q      <= '0;
      hold_q      <= '0;
      done_q      <= 1'b0;
      err_q       <= '0;
      fail_q      <= 1'b0;
      first_bad_q <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      up_q        <= up_d;
      pp_q        <= pp_d;
      step_q      <= step_d;
      hold_q      <= hold_d;
      done_q      <= done_d;
      err_q       <= err_d;
      fail_q      <= fail_d;
      first_bad_q <= first_bad_d;
    end
  end

  assign bus.SW        = sw_w;
  assign bus.BUSY      = (state_q == S_RUN);
  assign bus.DONE      = done_q;
  assign bus.STEP      = step_q;
  assign bus.ERR_CNT   = err_q;
  assign bus.FAIL      = fail_q;
  assign bus.FIRST_BAD = first_bad_q;

endmodule

// File: tb/tb_sw_sweep_gen.sv
// tb/tb_sw_sweep_gen.sv - directed bench for sw_sweep_gen with NIB_W=4, CHANNELS=3, HOLD=4
module tb_sw_sweep_gen;

  logic clk;
  logic rst_n;
  logic force_b0;
  int   n_cmp;
  int   n_bad;

  sw_sweep_gen_if #(.NIB_W(4), .CHANNELS(3), .ERR_W(8)) bus ();

  sw_sweep_gen #(.NIB_W(4), .CHANNELS(3), .HOLD(4), .ERR_W(8)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus.master)
  );

  assign bus.LED_IN = bus.SW | {11'b0, force_b0};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_x(input logic [1:0] m, input int k);
    case (m)
      2'd1:    return k;
      2'd2:    return (k <= 15) ? (15 - k) : (k - 15);
      default: return 15 - k;
    endcase
  endfunction

  task automatic pulse_start(input logic [1:0] m);
    bus.MODE  = m;
    bus.START = 1'b1;
    @(negedge clk);
    bus.START = 1'b0;
  endtask

  // Called at the negedge inside the first clock of step 0.
  task automatic sweep(input logic [1:0] m, input int nsteps, input int fa, input int fb,
                       input int gx, input int restart_k, input bit chain);
    int         ex;
    logic [3:0] xv;
    bit         last;
    for (int k = 0; k < nsteps; k++) begin
      for (int h = 0; h < 4; h++) begin
        ex   = exp_x(m, k);
        xv   = 4'(ex);
        last = (k == nsteps - 1) && (h == 3);
        force_b0  = ((h == 3) && (ex == fa || ex == fb)) || ((h == 1) && (ex == gx));
        bus.START = ((k == restart_k) && (h == 2)) || (chain && last);
        bus.MODE  = (chain && last) ? 2'd0 : 2'(k + 1);
        chk("sw",   32'(bus.SW),   32'({xv, xv, xv}));
        chk("busy", 32'(bus.BUSY), 32'd1);
        chk("step", 32'(bus.STEP), 32'(k));
        chk("done", 32'(bus.DONE), 32'd0);
        @(negedge clk);
      end
    end
    force_b0 = 1'b0;
    if (!chain) bus.START = 1'b0;
    chk("done_pulse", 32'(bus.DONE), 32'd1);
    chk("busy_end",   32'(bus.BUSY), 32'd0);
    if (!chain) begin
      @(negedge clk);
      chk("done_drop", 32'(bus.DONE), 32'd0);
    end
  endtask

  initial begin
    clk       = 1'b0;
    rst_n     = 1'b0;
    force_b0  = 1'b0;
    n_cmp     = 0;
    n_bad     = 0;
    bus.START = 1'b0;
    bus.MODE  = 2'd0;

    #1;
    chk("rst_sw",        32'(bus.SW),        32'h000);
    chk("rst_busy",      32'(bus.BUSY),      32'd0);
    chk("rst_done",      32'(bus.DONE),      32'd0);
    chk("rst_step",      32'(bus.STEP),      32'd0);
    chk("rst_err",       32'(bus.ERR_CNT),   32'd0);
    chk("rst_fail_flag", 32'(bus.FAIL),      32'd0);
    chk("rst_first_bad", 32'(bus.FIRST_BAD), 32'd0);
    #22 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("idle_busy", 32'(bus.BUSY), 32'd0);

    // Down sweep with a stray START mid-run.
    pulse_start(2'd0);
    sweep(2'd0, 16, -1, -1, -1, 5, 1'b0);
    chk("down_err",       32'(bus.ERR_CNT), 32'd0);
    chk("down_fail_flag", 32'(bus.FAIL),    32'd0);
    chk("down_step",      32'(bus.STEP),    32'd15);
    chk("down_sw",        32'(bus.SW),      32'h000);

    // Up sweep, final value held in IDLE.
    pulse_start(2'd1);
    sweep(2'd1, 16, -1, -1, -1, -1, 1'b0);
    chk("up_step", 32'(bus.STEP), 32'd15);
    chk("up_sw",   32'(bus.SW),   32'hFFF);
    @(negedge clk);
    chk("up_hold_sw",   32'(bus.SW),   32'hFFF);
    chk("up_hold_busy", 32'(bus.BUSY), 32'd0);

    // Ping-pong: 31 steps, 124 busy clocks.
    pulse_start(2'd2);
    sweep(2'd2, 31, -1, -1, -1, -1, 1'b0);
    chk("pp_step", 32'(bus.STEP),    32'd30);
    chk("pp_sw",   32'(bus.SW),      32'hFFF);
    chk("pp_err",  32'(bus.ERR_CNT), 32'd0);

    // Faults at X=4 and X=2, early-window glitch at X=6, START held across DONE.
    pulse_start(2'd0);
    sweep(2'd0, 16, 4, 2, 6, -1, 1'b1);
    chk("fault_err",       32'(bus.ERR_CNT),   32'd2);
    chk("fault_fail_flag", 32'(bus.FAIL),      32'd1);
    chk("fault_first_bad", 32'(bus.FIRST_BAD), 32'd4);
    @(negedge clk);
    bus.START = 1'b0;
    chk("chain_busy",      32'(bus.BUSY),      32'd1);
    chk("chain_err",       32'(bus.ERR_CNT),   32'd0);
    chk("chain_fail_flag", 32'(bus.FAIL),      32'd0);
    chk("chain_first_bad", 32'(bus.FIRST_BAD), 32'd0);
    sweep(2'd0, 16, -1, -1, -1, -1, 1'b0);
    chk("chain_end_err", 32'(bus.ERR_CNT), 32'd0);

    // MODE=3 runs as down.
    pulse_start(2'd3);
    sweep(2'd3, 16, -1, -1, -1, -1, 1'b0);
    chk("m3_sw",   32'(bus.SW),   32'h000);
    chk("m3_step", 32'(bus.STEP), 32'd15);

    // Asynchronous reset at step 7, off the clock edges.
    pulse_start(2'd0);
    repeat (7 * 4 + 1) @(negedge clk);
    chk("pre_rst_step", 32'(bus.STEP), 32'd7);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sw",        32'(bus.SW),        32'h000);
    chk("arst_busy",      32'(bus.BUSY),      32'd0);
    chk("arst_step",      32'(bus.STEP),      32'd0);
    chk("arst_done",      32'(bus.DONE),      32'd0);
    chk("arst_err",       32'(bus.ERR_CNT),   32'd0);
    chk("arst_fail_flag", 32'(bus.FAIL),      32'd0);
    chk("arst_first_bad", 32'(bus.FIRST_BAD), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("arst_no_done", 32'(bus.DONE), 32'd0);
    end
    #3 rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_busy", 32'(bus.BUSY), 32'd0);
      chk("post_rst_sw",   32'(bus.SW),   32'h000);
      chk("post_rst_done", 32'(bus.DONE), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
